edge_trigger_detect: RTL
========================

# edge_trigger_detect

Threshold edge detector that consumes the moving-sum stream produced by `mov_sum` (`sumout_V` / `sumout_V_ap_vld`) and emits a single-cycle trigger pulse on a qualified rising or falling crossing. It sits between the moving-sum stage and the capture trigger mux of the edge-trigger path. Hysteresis (separate qualify and fire thresholds) suppresses re-triggering on noise, and a programmable holdoff blocks re-arming after a fire.

## Interface
Parameters:
- `DATA_W`, 32, width of the signed sum input and thresholds
- `HOLD_W`, 16, width of the holdoff counter
- `CNT_W`, 16, width of the saturating trigger counter

Ports (one clock; reset is asynchronous and active-low):
- `ap_clk`  in  1  clock
- `ap_rst_n`  in  1  asynchronous active-low reset
- `arm`  in  1  pulse; accepted only in IDLE
- `disarm`  in  1  synchronous abort to IDLE; highest priority
- `auto_rearm`  in  1  after holdoff: 1 returns to QUALIFY, 0 returns to IDLE
- `polarity`  in  1  0 = rising (fire on sum > thr_hi), 1 = falling (fire on sum < thr_lo)
- `thr_hi`  in  DATA_W  signed upper threshold
- `thr_lo`  in  DATA_W  signed lower threshold
- `holdoff`  in  HOLD_W  holdoff length in cycles
- `sum_in`  in  DATA_W  signed moving sum (from `sumout_V`)
- `sum_vld`  in  1  sample strobe (from `sumout_V_ap_vld`)
- `trig_out`  out  1  single-cycle trigger pulse
- `armed`  out  1  high in QUALIFY or ARMED
- `trig_count`  out  CNT_W  saturating count of fires

## Operation
- States: IDLE, QUALIFY, ARMED, HOLDOFF.
- IDLE: `arm` -> QUALIFY; on acceptance latch `polarity`, `thr_hi`, `thr_lo`, `holdoff` into shadow registers and clear `trig_count`. Live inputs are ignored outside IDLE.
- QUALIFY (sample must first sit on the inactive side): on `sum_vld`, rising: `sum_in <= thr_lo` -> ARMED; falling: `sum_in >= thr_hi` -> ARMED.
- ARMED: on `sum_vld`, rising: `sum_in > thr_hi` fires; falling: `sum_in < thr_lo` fires. All comparisons are signed, full DATA_W, against shadow values.
- Fire: `trig_out` pulses, `trig_count` increments (holds at all-ones). If shadow holdoff == 0, go directly to QUALIFY (`auto_rearm`=1) or IDLE; else HOLDOFF with counter = holdoff.
- HOLDOFF: counter decrements every cycle regardless of `sum_vld`; at counter == 1 exit to QUALIFY or IDLE per `auto_rearm` sampled at exit.
- Non-`sum_vld` cycles never change state in QUALIFY/ARMED.
- `disarm` from any state -> IDLE next cycle; suppresses a fire in the same cycle; `trig_count` retained.
- `thr_lo > thr_hi` is legal; behaviour follows the comparisons literally.

## Timing
- Reset values: state IDLE, `trig_out` 0, `armed` 0, `trig_count` 0, shadows 0.
- `arm` in cycle N -> `armed` high in N+1.
- Firing sample with `sum_vld` in cycle N -> `trig_out` high in N+1 only; `trig_count` updated in N+1.
- HOLDOFF occupies exactly `holdoff` cycles (N+1 .. N+holdoff); `armed` low throughout; earliest QUALIFY transition uses a sample in N+holdoff+1.
- A sample that qualifies in QUALIFY cannot also fire; firing needs a later `sum_vld`.
- Back-to-back `sum_vld` every cycle supported; no backpressure toward `mov_sum`.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.

## Structure
- Package `edge_trig_pkg`: state enum (IDLE, QUALIFY, ARMED, HOLDOFF), default widths DATA_W/HOLD_W/CNT_W.
- Sub-module `edge_trig_holdoff`: loadable down-counter with `load`, `value`, `done` (asserted at count 1) outputs; top holds FSM, compares, shadows, counter.

## Test plan
- Rising, thr_lo=100, thr_hi=200, holdoff=0, auto_rearm=0: sums 50,150,250 -> one `trig_out` cycle after 250, `trig_count`=1, return to IDLE.
- Hysteresis: rising, thr_lo=100, thr_hi=200, auto_rearm=1: 250 (no fire, not qualified), 50, 250, 199, 250, 90, 201 -> exactly two fires (first 250 after 50, then 201); the 250 after 199 does not fire.
- Falling, thr_lo=-300, thr_hi=-100, holdoff=5, auto_rearm=1: -50, -400 -> fire; `armed` low for 5 cycles; sample during holdoff ignored.
- Shadow latch: arm with thr_hi=200, then change thr_hi to 0 while ARMED; sum 100 -> no fire.
- Disarm priority: firing sample and `disarm` in same cycle -> no `trig_out`, IDLE next cycle, `trig_count` unchanged.
- Saturation/reset: CNT_W=2, four fires -> `trig_count`=3; assert `ap_rst_n` low mid-HOLDOFF -> all outputs 0 immediately.

Source files
------------

// File: rtl/edge_trig_pkg.sv
// edge_trig_pkg: shared state encoding and default widths for the edge trigger path.
package edge_trig_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_HOLD_W = 16;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, QUALIFY, ARMED, HOLDOFF} state_t;
endpackage

// File: rtl/edge_trig_holdoff.sv
// edge_trig_holdoff: loadable down-counter; done marks the last holdoff cycle (count 1).
module edge_trig_holdoff import edge_trig_pkg::*; #(
  parameter int W = DEF_HOLD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         done
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= '0;
    else if (load) value <= load_val;
    else if (value != '0) value <= value - W'(1);
  assign done = value == W'(1);
endmodule

// File: rtl/edge_trigger_detect.sv
// edge_trigger_detect: hysteresis threshold crossing detector on the moving-sum stream,
// emitting a one-cycle trigger with optional holdoff and auto re-arm.
module edge_trigger_detect import edge_trig_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int HOLD_W = DEF_HOLD_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     arm,
  input  logic                     disarm,
  input  logic                     auto_rearm,
  input  logic                     polarity,
  input  logic signed [DATA_W-1:0] thr_hi,
  input  logic signed [DATA_W-1:0] thr_lo,
  input  logic        [HOLD_W-1:0] holdoff,
  input  logic signed [DATA_W-1:0] sum_in,
  input  logic                     sum_vld,
  output logic                     trig_out,
  output logic                     armed,
  output logic        [CNT_W-1:0]  trig_count
);
  state_t state, state_nxt;
  logic pol_s;
  logic signed [DATA_W-1:0] hi_s, lo_s;
  logic [HOLD_W-1:0] hold_s, hold_val;
  logic hold_done, fire, accept, qual, hit;
  // Thresholds are compared against the values captured at arm time, never the live ports.
  assign qual = pol_s ? (sum_in >= hi_s) : (sum_in <= lo_s);
  assign hit = pol_s ? (sum_in < lo_s) : (sum_in > hi_s);
  assign accept = state == IDLE && arm && !disarm;
  assign armed = state == QUALIFY || state == ARMED;
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    fire = 1'b0;
    if (disarm) state_nxt = IDLE;
    else
      case (state)
        IDLE: state_nxt = arm ? QUALIFY : IDLE;
        QUALIFY: state_nxt = sum_vld && qual ? ARMED : QUALIFY;
        ARMED: if (sum_vld && hit) begin
          fire = 1'b1;
          state_nxt = hold_s != '0 ? HOLDOFF : auto_rearm ? QUALIFY : IDLE;
        end
        HOLDOFF: state_nxt = hold_done ? (auto_rearm ? QUALIFY : IDLE) : HOLDOFF;
        default: state_nxt = IDLE;
      endcase
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      pol_s <= 1'b0;
      hi_s <= '0;
      lo_s <= '0;
      hold_s <= '0;
    end else if (accept) begin
      pol_s <= polarity;
      hi_s <= thr_hi;
      lo_s <= thr_lo;
      hold_s <= holdoff;
    end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      trig_out <= 1'b0;
      trig_count <= '0;
    end else begin
      trig_out <= fire;
      if (accept) trig_count <= '0;
      else if (fire && !(&trig_count)) trig_count <= trig_count + CNT_W'(1);
    end
  edge_trig_holdoff #(.W(HOLD_W)) u_holdoff (
    .clk(ap_clk),
    .rst_n(ap_rst_n),
    .load(fire),
    .load_val(hold_s),
    .value(hold_val),
    .done(hold_done)
  );
  a_holdoff_live: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    state == HOLDOFF |-> hold_val != '0);
endmodule
